// File: rtl/axis_rr_merge.sv
// axis_rr_merge: packet-aware round-robin merge of NUM_SRC AXI-Stream
// sources into one registered master stream tagged with the source id.
module axis_rr_merge #(
    parameter int C_AXIS_TDATA_WIDTH = 32,
    parameter int NUM_SRC            = 2,
    parameter int PKT_MODE           = 1,
    parameter int SRC_ID_WIDTH       = 2
) (
    input  logic                                  axis_aclk,
    input  logic                                  axis_areset,
    input  logic [NUM_SRC-1:0]                    s_axis_tvalid,
    output logic [NUM_SRC-1:0]                    s_axis_tready,
    input  logic [NUM_SRC*C_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_SRC*C_AXIS_TDATA_WIDTH/8-1:0] s_axis_tstrb,
    input  logic [NUM_SRC-1:0]                    s_axis_tlast,
    output logic                                  m_axis_tvalid,
    input  logic                                  m_axis_tready,
    output logic [C_AXIS_TDATA_WIDTH-1:0]         m_axis_tdata,
    output logic [C_AXIS_TDATA_WIDTH/8-1:0]       m_axis_tstrb,
    output logic                                  m_axis_tlast,
    output logic [SRC_ID_WIDTH-1:0]               m_axis_tid
);

    localparam int DW = C_AXIS_TDATA_WIDTH;
    localparam int SW = C_AXIS_TDATA_WIDTH / 8;

    typedef enum logic {
        IDLE = 1'b0,
        PASS = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [SRC_ID_WIDTH-1:0] grant_q, grant_d;
    logic [SRC_ID_WIDTH-1:0] last_grant_q, last_grant_d;
    logic                    m_valid_q, m_valid_d;
    logic [DW-1:0]           m_data_q, m_data_d;
    logic [SW-1:0]           m_strb_q, m_strb_d;
    logic                    m_last_q, m_last_d;
    logic [SRC_ID_WIDTH-1:0] m_tid_q, m_tid_d;

    logic                    sel_valid;
    logic                    sel_last;
    logic [DW-1:0]           sel_data;
    logic [SW-1:0]           sel_strb;
    logic                    rr_found;
    logic [SRC_ID_WIDTH-1:0] rr_pick;
    logic                    room;
    logic                    accept;

    // State register: FSM, grant lock and the output beat register
    always_ff @(posedge axis_aclk) begin
        if (axis_areset) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= SRC_ID_WIDTH'(NUM_SRC - 1);
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
            m_strb_q     <= '0;
            m_last_q     <= 1'b0;
            m_tid_q      <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            m_valid_q    <= m_valid_d;
            m_data_q     <= m_data_d;
            m_strb_q     <= m_strb_d;
            m_last_q     <= m_last_d;
            m_tid_q      <= m_tid_d;
        end
    end

    // Mux the currently granted source onto the sel_* lines
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        sel_strb  = '0;
        for (int j = 0; j < NUM_SRC; j++) begin
            if (grant_q == SRC_ID_WIDTH'(j)) begin
                sel_valid = s_axis_tvalid[j];
                sel_last  = s_axis_tlast[j];
                sel_data  = s_axis_tdata[j*DW +: DW];
                sel_strb  = s_axis_tstrb[j*SW +: SW];
            end
        end
    end

    // Round-robin search: first valid source after last_grant, wrapping
    always_comb begin
        rr_found = 1'b0;
        rr_pick  = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            for (int j = 0; j < NUM_SRC; j++) begin
                if (!rr_found && s_axis_tvalid[j] &&
                    ((int'(last_grant_q) + k) % NUM_SRC) == j) begin
                    rr_found = 1'b1;
                    rr_pick  = SRC_ID_WIDTH'(j);
                end
            end
        end
    end

    // Next state: lock a grant in IDLE, release it on the closing beat
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (rr_found) begin
                    grant_d = rr_pick;
                    state_d = PASS;
                end
            end
            PASS: begin
                if (accept && ((PKT_MODE == 0) || sel_last)) begin
                    last_grant_d = grant_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: ready to the granted source only, and the output register
    always_comb begin
        room          = !m_valid_q || m_axis_tready;
        s_axis_tready = '0;
        if (state_q == PASS) begin
            for (int j = 0; j < NUM_SRC; j++) begin
                if (grant_q == SRC_ID_WIDTH'(j)) begin
                    s_axis_tready[j] = room;
                end
            end
        end
        accept    = (state_q == PASS) && room && sel_valid;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_strb_d  = m_strb_q;
        m_last_d  = m_last_q;
        m_tid_d   = m_tid_q;
        if (accept) begin
            m_valid_d = 1'b1;
            m_data_d  = sel_data;
            m_strb_d  = sel_strb;
            m_last_d  = sel_last;
            m_tid_d   = grant_q;
        end else if (m_valid_q && m_axis_tready) begin
            m_valid_d = 1'b0;
        end
    end

    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tdata  = m_data_q;
    assign m_axis_tstrb  = m_strb_q;
    assign m_axis_tlast  = m_last_q;
    assign m_axis_tid    = m_tid_q;

endmodule

// File: tb/tb_axis_rr_merge.sv
// tb_axis_rr_merge: directed vector table on a packet-mode instance plus
// a reactive two-source sequence on a beat-mode instance.
module tb_axis_rr_merge;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  sv;
    logic [1:0]  sl;
    logic [63:0] sd;
    logic [7:0]  ss;
    logic        mr;

    logic [1:0]  p_sr;
    logic        p_mv;
    logic [31:0] p_md;
    logic [3:0]  p_ms;
    logic        p_ml;
    logic [1:0]  p_mid;

    logic [1:0]  b_sr;
    logic        b_mv;
    logic [31:0] b_md;
    logic [3:0]  b_ms;
    logic        b_ml;
    logic [1:0]  b_mid;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axis_rr_merge #(
        .C_AXIS_TDATA_WIDTH(32),
        .NUM_SRC(2),
        .PKT_MODE(1),
        .SRC_ID_WIDTH(2)
    ) dut_pkt (
        .axis_aclk(clk),
        .axis_areset(rst),
        .s_axis_tvalid(sv),
        .s_axis_tready(p_sr),
        .s_axis_tdata(sd),
        .s_axis_tstrb(ss),
        .s_axis_tlast(sl),
        .m_axis_tvalid(p_mv),
        .m_axis_tready(mr),
        .m_axis_tdata(p_md),
        .m_axis_tstrb(p_ms),
        .m_axis_tlast(p_ml),
        .m_axis_tid(p_mid)
    );

    axis_rr_merge #(
        .C_AXIS_TDATA_WIDTH(32),
        .NUM_SRC(2),
        .PKT_MODE(0),
        .SRC_ID_WIDTH(2)
    ) dut_beat (
        .axis_aclk(clk),
        .axis_areset(rst),
        .s_axis_tvalid(sv),
        .s_axis_tready(b_sr),
        .s_axis_tdata(sd),
        .s_axis_tstrb(ss),
        .s_axis_tlast(sl),
        .m_axis_tvalid(b_mv),
        .m_axis_tready(mr),
        .m_axis_tdata(b_md),
        .m_axis_tstrb(b_ms),
        .m_axis_tlast(b_ml),
        .m_axis_tid(b_mid)
    );

    typedef struct {
        logic       rst;
        logic [1:0] v;
        logic [1:0] l;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       mr;
        logic       ev;
        logic [7:0] ed;
        logic       el;
        logic [1:0] eid;
        logic [1:0] er;
    } vec_t;

    localparam int NV = 48;
    vec_t tv[NV];

    function automatic vec_t mk(input logic r, input logic [1:0] v,
                                input logic [1:0] l, input logic [7:0] d0,
                                input logic [7:0] d1, input logic m,
                                input logic ev, input logic [7:0] ed,
                                input logic el, input logic [1:0] eid,
                                input logic [1:0] er);
        vec_t t;
        t.rst = r; t.v = v; t.l = l; t.d0 = d0; t.d1 = d1; t.mr = m;
        t.ev = ev; t.ed = ed; t.el = el; t.eid = eid; t.er = er;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [1:0] v,
                         input logic [1:0] l, input logic [7:0] d0,
                         input logic [7:0] d1, input logic m);
        rst = r;
        sv  = v;
        sl  = l;
        sd  = {24'h0, d1, 24'h0, d0};
        mr  = m;
    endtask

    logic [7:0] exp_d[4];
    logic [1:0] exp_id[4];
    logic [7:0] got_d[4];
    logic [1:0] got_id[4];
    int         nb;
    int         c0;
    int         c1;
    logic       a0;
    logic       a1;

    initial begin
        // rst, v, l, d0, d1, mr | ev, ed, el, eid, er
        // src0 alone: 3-beat packet, first m_valid two cycles after s_valid
        tv[0]  = mk(1, 2'b00, 2'b00, 8'h00, 8'h00, 1, 0, 8'h00, 0, 0, 2'b00);
        tv[1]  = mk(0, 2'b01, 2'b00, 8'hA0, 8'h00, 1, 0, 8'h00, 0, 0, 2'b00);
        tv[2]  = mk(0, 2'b01, 2'b00, 8'hA0, 8'h00, 1, 0, 8'h00, 0, 0, 2'b01);
        tv[3]  = mk(0, 2'b01, 2'b00, 8'hA1, 8'h00, 1, 1, 8'hA0, 0, 0, 2'b01);
        tv[4]  = mk(0, 2'b01, 2'b01, 8'hA2, 8'h00, 1, 1, 8'hA1, 0, 0, 2'b01);
        tv[5]  = mk(0, 2'b00, 2'b00, 8'h00, 8'h00, 1, 1, 8'hA2, 1, 0, 2'b00);
        tv[6]  = mk(0, 2'b00, 2'b00, 8'h00, 8'h00, 1, 0, 8'h00, 0, 0, 2'b00);
        // both sources, 2-beat packets, no interleave
        tv[7]  = mk(1, 2'b00, 2'b00, 8'h00, 8'h00, 1, 0, 8'h00, 0, 0, 2'b00);
        tv[8]  = mk(0, 2'b11, 2'b00, 8'h10, 8'h20, 1, 0, 8'h00, 0, 0, 2'b00);
        tv[9]  = mk(0, 2'b11, 2'b00, 8'h10, 8'h20, 1, 0, 8'h00, 0, 0, 2'b01);
        tv[10] = mk(0, 2'b11, 2'b01, 8'h11, 8'h20, 1, 1, 8'h10, 0, 0, 2'b01);
        tv[11] = mk(0, 2'b11, 2'b00, 8'h10, 8'h20, 1, 1, 8'h11, 1, 0, 2'b00);
        tv[12] = mk(0, 2'b11, 2'b00, 8'h10, 8'h20, 1, 0, 8'h00, 0, 0, 2'b10);
        tv[13] = mk(0, 2'b11, 2'b10, 8'h10, 8'h21, 1, 1, 8'h20, 0, 1, 2'b10);
        tv[14] = mk(0, 2'b11, 2'b00, 8'h10, 8'h20, 1, 1, 8'h21, 1, 1, 2'b00);
        tv[15] = mk(0, 2'b11, 2'b00, 8'h10, 8'h20, 1, 0, 8'h00, 0, 0, 2'b01);
        tv[16] = mk(0, 2'b01, 2'b01, 8'h11, 8'h00, 1, 1, 8'h10, 0, 0, 2'b01);
        tv[17] = mk(0, 2'b00, 2'b00, 8'h00, 8'h00, 1, 1, 8'h11, 1, 0, 2'b00);
        tv[18] = mk(0, 2'b00, 2'b00, 8'h00, 8'h00, 1, 0, 8'h00, 0, 0, 2'b00);
        // src1 packet with m_ready low for 4 cycles while the register is full
        tv[19] = mk(0, 2'b10, 2'b00, 8'h00, 8'h30, 1, 0, 8'h00, 0, 0, 2'b00);
        tv[20] = mk(0, 2'b10, 2'b00, 8'h00, 8'h30, 1, 0, 8'h00, 0, 0, 2'b10);
        tv[21] = mk(0, 2'b10, 2'b00, 8'h00, 8'h31, 1, 1, 8'h30, 0, 1, 2'b10);
        tv[22] = mk(0, 2'b10, 2'b10, 8'h00, 8'h32, 0, 1, 8'h31, 0, 1, 2'b00);
        tv[23] = mk(0, 2'b10, 2'b10, 8'h00, 8'h32, 0, 1, 8'h31, 0, 1, 2'b00);
        tv[24] = mk(0, 2'b10, 2'b10, 8'h00, 8'h32, 0, 1, 8'h31, 0, 1, 2'b00);
        tv[25] = mk(0, 2'b10, 2'b10, 8'h00, 8'h32, 0, 1, 8'h31, 0, 1, 2'b00);
        tv[26] = mk(0, 2'b10, 2'b10, 8'h00, 8'h32, 1, 1, 8'h31, 0, 1, 2'b10);
        tv[27] = mk(0, 2'b00, 2'b00, 8'h00, 8'h00, 1, 1, 8'h32, 1, 1, 2'b00);
        tv[28] = mk(0, 2'b00, 2'b00, 8'h00, 8'h00, 1, 0, 8'h00, 0, 0, 2'b00);
        // src1 locked and pausing mid-packet while src0 waits
        tv[29] = mk(0, 2'b10, 2'b00, 8'h50, 8'h40, 1, 0, 8'h00, 0, 0, 2'b00);
        tv[30] = mk(0, 2'b11, 2'b01, 8'h50, 8'h40, 1, 0, 8'h00, 0, 0, 2'b10);
        tv[31] = mk(0, 2'b01, 2'b01, 8'h50, 8'h40, 1, 1, 8'h40, 0, 1, 2'b10);
        tv[32] = mk(0, 2'b01, 2'b01, 8'h50, 8'h40, 1, 0, 8'h00, 0, 0, 2'b10);
        tv[33] = mk(0, 2'b01, 2'b01, 8'h50, 8'h40, 1, 0, 8'h00, 0, 0, 2'b10);
        tv[34] = mk(0, 2'b11, 2'b11, 8'h50, 8'h41, 1, 0, 8'h00, 0, 0, 2'b10);
        tv[35] = mk(0, 2'b01, 2'b01, 8'h50, 8'h00, 1, 1, 8'h41, 1, 1, 2'b00);
        tv[36] = mk(0, 2'b01, 2'b01, 8'h50, 8'h00, 1, 0, 8'h00, 0, 0, 2'b01);
        tv[37] = mk(0, 2'b00, 2'b00, 8'h00, 8'h00, 1, 1, 8'h50, 1, 0, 2'b00);
        tv[38] = mk(0, 2'b00, 2'b00, 8'h00, 8'h00, 1, 0, 8'h00, 0, 0, 2'b00);
        // reset mid-packet of src1, then src0 wins the next arbitration
        tv[39] = mk(0, 2'b10, 2'b00, 8'h00, 8'h60, 1, 0, 8'h00, 0, 0, 2'b00);
        tv[40] = mk(0, 2'b10, 2'b00, 8'h00, 8'h60, 1, 0, 8'h00, 0, 0, 2'b10);
        tv[41] = mk(1, 2'b10, 2'b00, 8'h00, 8'h61, 1, 1, 8'h60, 0, 1, 2'b10);
        tv[42] = mk(0, 2'b11, 2'b01, 8'h70, 8'h61, 1, 0, 8'h00, 0, 0, 2'b00);
        tv[43] = mk(0, 2'b11, 2'b01, 8'h70, 8'h61, 1, 0, 8'h00, 0, 0, 2'b01);
        tv[44] = mk(0, 2'b10, 2'b00, 8'h00, 8'h61, 1, 1, 8'h70, 1, 0, 2'b00);
        tv[45] = mk(0, 2'b10, 2'b10, 8'h00, 8'h61, 1, 0, 8'h00, 0, 0, 2'b10);
        tv[46] = mk(0, 2'b00, 2'b00, 8'h00, 8'h00, 1, 1, 8'h61, 1, 1, 2'b00);
        tv[47] = mk(0, 2'b00, 2'b00, 8'h00, 8'h00, 1, 0, 8'h00, 0, 0, 2'b00);

        ss = {4'h3, 4'hF};
        drive(1, 2'b00, 2'b00, 8'h00, 8'h00, 1);
        repeat (2) @(posedge clk);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(tv[i].rst, tv[i].v, tv[i].l, tv[i].d0, tv[i].d1, tv[i].mr);
            #1;
            chk($sformatf("v%0d m_valid", i), 32'(p_mv), 32'(tv[i].ev));
            chk($sformatf("v%0d s_ready", i), 32'(p_sr), 32'(tv[i].er));
            if (tv[i].ev) begin
                chk($sformatf("v%0d m_data", i), p_md, {24'h0, tv[i].ed});
                chk($sformatf("v%0d m_last", i), 32'(p_ml), 32'(tv[i].el));
                chk($sformatf("v%0d m_tid", i), 32'(p_mid), 32'(tv[i].eid));
                chk($sformatf("v%0d m_strb", i), 32'(p_ms),
                    (tv[i].eid == 2'd1) ? 32'h3 : 32'hF);
            end
        end

        // beat mode: both sources hold 2-beat packets, beats alternate
        exp_d[0] = 8'h10; exp_id[0] = 2'd0;
        exp_d[1] = 8'h20; exp_id[1] = 2'd1;
        exp_d[2] = 8'h11; exp_id[2] = 2'd0;
        exp_d[3] = 8'h21; exp_id[3] = 2'd1;
        @(negedge clk);
        drive(1, 2'b00, 2'b00, 8'h00, 8'h00, 1);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("beat reset m_valid", 32'(b_mv), 32'h0);
        chk("beat reset s_ready", 32'(b_sr), 32'h0);
        @(posedge clk);
        nb = 0;
        c0 = 0;
        c1 = 0;
        for (int cyc = 0; cyc < 40 && nb < 4; cyc++) begin
            @(negedge clk);
            drive(0, 2'b11, {1'(c1 % 2), 1'(c0 % 2)},
                  8'h10 + 8'(c0 % 2), 8'h20 + 8'(c1 % 2), 1);
            #1;
            if (b_mv) begin
                got_d[nb]  = b_md[7:0];
                got_id[nb] = b_mid;
                nb++;
            end
            a0 = b_sr[0];
            a1 = b_sr[1];
            @(posedge clk);
            if (a0) c0++;
            if (a1) c1++;
        end
        checks++;
        if (nb != 4) begin
            errors++;
            $display("FAIL beat timeout: got %0d beats expected 4", nb);
        end
        for (int k = 0; k < nb; k++) begin
            chk($sformatf("beat%0d data", k), 32'(got_d[k]), 32'(exp_d[k]));
            chk($sformatf("beat%0d tid", k), 32'(got_id[k]), 32'(exp_id[k]));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_rr_merge.md
Name: axis_rr_merge

Overview:
- Packet-aware round-robin arbiter that merges NUM_SRC AXI-Stream sources into one master stream.
- The merged stream feeds the stream splitter, so several producers share one splitter instance.
- Grant is locked for a whole packet (until an accepted tlast beat) in packet mode, or rotates every beat in beat mode.
- Output is registered; the winning source index is emitted on m_axis_tid.

Parameters:
- C_AXIS_TDATA_WIDTH, 32, data width of every port; multiple of 8.
- NUM_SRC, 2, number of sources; legal values 2..4.
- PKT_MODE, 1, 1 = hold grant until an accepted tlast beat; 0 = re-arbitrate after every accepted beat.
- SRC_ID_WIDTH, 2, width of m_axis_tid; must be ≥ clog2(NUM_SRC).

Ports:
- axis_aclk  in  1  clock; all logic on rising edge.
- axis_areset  in  1  synchronous, active-high reset.
- s_axis_tvalid  in  NUM_SRC  per-source valid.
- s_axis_tready  out  NUM_SRC  per-source ready.
- s_axis_tdata  in  NUM_SRC*C_AXIS_TDATA_WIDTH  packed data; source i at slice i.
- s_axis_tstrb  in  NUM_SRC*C_AXIS_TDATA_WIDTH/8  packed strobes.
- s_axis_tlast  in  NUM_SRC  per-source last.
- m_axis_tvalid  out  1  merged valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tdata  out  C_AXIS_TDATA_WIDTH  merged data.
- m_axis_tstrb  out  C_AXIS_TDATA_WIDTH/8  merged strobes.
- m_axis_tlast  out  1  merged last.
- m_axis_tid  out  SRC_ID_WIDTH  index of the source that produced the beat.

Behaviour:
- Reset values: m_axis_tvalid=0, m_axis_tdata=0, m_axis_tstrb=0, m_axis_tlast=0, m_axis_tid=0, s_axis_tready=0, state=IDLE, grant=0, last_grant=NUM_SRC-1 (source 0 has first priority).
- Reset mid-operation: the output register beat and the lock are discarded. There is no partial-packet recovery.
- FSM states: IDLE, PASS.
- IDLE: all s_axis_tready=0. If any s_axis_tvalid is set, grant is registered as the first valid source searching last_grant+1, last_grant+2, … modulo NUM_SRC; go to PASS. If none is valid, stay in IDLE.
- PASS: s_axis_tready[grant] = (!m_axis_tvalid || m_axis_tready). All other readies are 0. Ready never depends on s_axis_tvalid.
- Accept = s_axis_tvalid[grant] && s_axis_tready[grant].
- On accept, the output register loads data, strobe and last from source grant, sets m_axis_tid=grant and m_axis_tvalid=1.
- If m_axis_tvalid && m_axis_tready and there is no accept, m_axis_tvalid clears. Output is held stable while m_axis_tvalid && !m_axis_tready.
- PASS exit: on accept with PKT_MODE=1 && tlast, or any accept with PKT_MODE=0, last_grant<=grant and go to IDLE.
- Granted source deasserts valid mid-packet: stay in PASS; the lock holds and no other source is served.
- Latency: a valid beat arriving at cycle 0 in IDLE is granted at edge 0, accepted at edge 1, and shows m_axis_tvalid in cycle 2. Each packet costs one IDLE bubble.
- Throughput: 1 beat/cycle within a packet while m_axis_tready=1.
- Simultaneous requests are resolved purely by round-robin order from last_grant; no source can be starved.
- m_axis_tready low with the register full: source ready=0; the register holds and nothing is lost or duplicated.

Test Plan:
- Reset, then only src0 sends a 3-beat packet 0xA0,0xA1,0xA2 (tlast on beat 3), m_axis_tready=1. Expect m beats in that order with tid=0, tlast on the 3rd, first m_axis_tvalid 2 cycles after s_axis_tvalid.
- src0 and src1 both hold 2-beat packets continuously (src0 0x10,0x11; src1 0x20,0x21), PKT_MODE=1. Expect order 0x10,0x11,0x20,0x21,0x10,… with tid 0,0,1,1,0 and no interleaving inside a packet.
- PKT_MODE=0, same stimulus as the previous test. Expect beats alternating by source, tid 0,1,0,1.
- Mid-packet of src1, drop m_axis_tready for 4 cycles. Expect m_axis_tdata/tlast/tid stable, s_axis_tready[1]=0 after the register fills, and no beat lost or duplicated after release.
- src1 granted and pauses valid for 3 cycles mid-packet while src0 is valid. Expect src0 not served until src1's tlast beat is accepted.
- Assert axis_areset for 1 cycle mid-packet. Expect m_axis_tvalid=0 and s_axis_tready=0 the next cycle. The next arbitration grants src0 first if it is valid.
